// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register ahead of the 32-bit execute ALU: decodes ALUOp/funct
// into ALUControl, forms the A/B operands and registers control for EX/MEM.
module id_ex_alu_stage #(
    parameter int          DW       = 32,
    parameter logic [3:0]  NOP_CTRL = 4'b0010
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Stall,
    input  logic          Flush,
    input  logic          InValid,
    input  logic [2:0]    ALUOp,
    input  logic          ALUSrc,
    input  logic          ZeroExt,
    input  logic [15:0]   Imm16,
    input  logic [4:0]    RsIdx,
    input  logic [4:0]    RtIdx,
    input  logic [4:0]    RdIdx,
    input  logic [DW-1:0] RegData1,
    input  logic [DW-1:0] RegData2,
    input  logic          RegWrite,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic          MemToReg,
    input  logic          Branch,
    input  logic          RegDst,
    output logic          OutValid,
    output logic [3:0]    ALUControl,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [DW-1:0] StoreData,
    output logic [4:0]    DestIdx,
    output logic [4:0]    RsIdxQ,
    output logic [4:0]    RtIdxQ,
    output logic          RegWriteQ,
    output logic          MemReadQ,
    output logic          MemWriteQ,
    output logic          MemToRegQ,
    output logic          BranchQ,
    output logic          IllegalOp
);

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_RTYPE = 3'b010,
        OP_ANDI  = 3'b011,
        OP_ORI   = 3'b100,
        OP_SLTI  = 3'b101,
        OP_SPEC2 = 3'b110
    } aluop_e;

    logic [5:0]    w_funct;
    logic [DW-1:0] w_imm_ext;
    logic [3:0]    w_ctrl;
    logic          w_illegal;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic          w_bubble;

    logic          r_valid;
    logic [3:0]    r_ctrl;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_store;
    logic [4:0]    r_dest;
    logic [4:0]    r_rs;
    logic [4:0]    r_rt;
    logic          r_regwrite;
    logic          r_memread;
    logic          r_memwrite;
    logic          r_memtoreg;
    logic          r_branch;
    logic          r_illegal;

    assign w_funct   = Imm16[5:0];
    assign w_imm_ext = ZeroExt ? {{(DW-16){1'b0}}, Imm16} : {{(DW-16){Imm16[15]}}, Imm16};

    always_comb begin
        w_ctrl    = 4'b0010;
        w_illegal = 1'b0;
        w_a       = RegData1;
        w_b       = ALUSrc ? w_imm_ext : RegData2;
        case (ALUOp)
            OP_ADD:  w_ctrl = 4'b0010;
            OP_SUB:  w_ctrl = 4'b0110;
            OP_ANDI: w_ctrl = 4'b0000;
            OP_ORI:  w_ctrl = 4'b0001;
            OP_SLTI: w_ctrl = 4'b0111;
            OP_RTYPE: begin
                case (w_funct)
                    6'b100000: w_ctrl = 4'b0010;
                    6'b100010: w_ctrl = 4'b0110;
                    6'b100100: w_ctrl = 4'b0000;
                    6'b100101: w_ctrl = 4'b0001;
                    6'b100111: w_ctrl = 4'b0011;
                    6'b101010: w_ctrl = 4'b0111;
                    6'b101011: w_ctrl = 4'b1011;
                    6'b001000: w_ctrl = 4'b1000;
                    6'b000000: begin
                        // shamt rides in B[10:6]; the shifter picks it out itself
                        w_ctrl = 4'b1010;
                        w_a    = RegData2;
                        w_b    = {{(DW-16){1'b0}}, Imm16};
                    end
                    6'b000010: begin
                        if (RsIdx[0]) begin
                            w_ctrl = 4'b1101;
                            w_a    = RegData2;
                            w_b    = {{(DW-5){1'b0}}, Imm16[10:6]};
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_SPEC2: begin
                case (w_funct)
                    6'b000010: w_ctrl = 4'b1001;
                    6'b100001: begin
                        w_ctrl = 4'b1100;
                        w_b    = DW'(1);
                    end
                    6'b100000: begin
                        w_ctrl = 4'b1100;
                        w_b    = '0;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Rst > Flush > Stall > load; an invalid slot loads a bubble only when not stalled
    assign w_bubble = Rst || Flush || (!Stall && !InValid);

    always_ff @(posedge Clk) begin
        if (w_bubble) begin
            r_valid    <= 1'b0;
            r_ctrl     <= NOP_CTRL;
            r_a        <= '0;
            r_b        <= '0;
            r_store    <= '0;
            r_dest     <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_branch   <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (!Stall) begin
            r_valid    <= 1'b1;
            r_ctrl     <= w_ctrl;
            r_a        <= w_a;
            r_b        <= w_b;
            r_store    <= RegData2;
            r_dest     <= RegDst ? RdIdx : RtIdx;
            r_rs       <= RsIdx;
            r_rt       <= RtIdx;
            r_regwrite <= RegWrite;
            r_memread  <= MemRead;
            r_memwrite <= MemWrite;
            r_memtoreg <= MemToReg;
            r_branch   <= Branch;
            r_illegal  <= w_illegal;
        end
    end

    assign OutValid   = r_valid;
    assign ALUControl = r_ctrl;
    assign A          = r_a;
    assign B          = r_b;
    assign StoreData  = r_store;
    assign DestIdx    = r_dest;
    assign RsIdxQ     = r_rs;
    assign RtIdxQ     = r_rt;
    assign RegWriteQ  = r_regwrite;
    assign MemReadQ   = r_memread;
    assign MemWriteQ  = r_memwrite;
    assign MemToRegQ  = r_memtoreg;
    assign BranchQ    = r_branch;
    assign IllegalOp  = r_illegal;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Scoreboard bench for id_ex_alu_stage: each driven cycle pushes the predicted
// output bundle, which is popped and compared one edge later.
module tb_id_ex_alu_stage;

    typedef struct packed {
        logic        valid;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  dest;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        br;
        logic        ill;
    } exp_t;

    logic        Clk;
    logic        Rst, Stall, Flush, InValid;
    logic [2:0]  ALUOp;
    logic        ALUSrc, ZeroExt;
    logic [15:0] Imm16;
    logic [4:0]  RsIdx, RtIdx, RdIdx;
    logic [31:0] RegData1, RegData2;
    logic        RegWrite, MemRead, MemWrite, MemToReg, Branch, RegDst;
    logic        OutValid;
    logic [3:0]  ALUControl;
    logic [31:0] A, B, StoreData;
    logic [4:0]  DestIdx, RsIdxQ, RtIdxQ;
    logic        RegWriteQ, MemReadQ, MemWriteQ, MemToRegQ, BranchQ, IllegalOp;

    exp_t w_got;
    exp_t sb[$];
    exp_t last;
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    id_ex_alu_stage #(.DW(32), .NOP_CTRL(4'b0010)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
        .ALUOp(ALUOp), .ALUSrc(ALUSrc), .ZeroExt(ZeroExt), .Imm16(Imm16),
        .RsIdx(RsIdx), .RtIdx(RtIdx), .RdIdx(RdIdx),
        .RegData1(RegData1), .RegData2(RegData2),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .Branch(Branch), .RegDst(RegDst),
        .OutValid(OutValid), .ALUControl(ALUControl), .A(A), .B(B),
        .StoreData(StoreData), .DestIdx(DestIdx), .RsIdxQ(RsIdxQ), .RtIdxQ(RtIdxQ),
        .RegWriteQ(RegWriteQ), .MemReadQ(MemReadQ), .MemWriteQ(MemWriteQ),
        .MemToRegQ(MemToRegQ), .BranchQ(BranchQ), .IllegalOp(IllegalOp)
    );

    assign w_got = {OutValid, ALUControl, A, B, StoreData, DestIdx, RsIdxQ, RtIdxQ,
                    RegWriteQ, MemReadQ, MemWriteQ, MemToRegQ, BranchQ, IllegalOp};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic exp_t bubble();
        exp_t b;
        b = '0;
        b.ctrl = 4'b0010;
        return b;
    endfunction

    // Reference decode written from the opcode table, independent of the RTL structure
    function automatic exp_t model();
        exp_t m;
        logic [5:0] f;
        if (Rst || Flush) return bubble();
        if (Stall) return last;
        if (!InValid) return bubble();
        f = Imm16[5:0];
        m = '0;
        m.valid = 1'b1;
        m.sd    = RegData2;
        m.dest  = RegDst ? RdIdx : RtIdx;
        m.rs    = RsIdx;
        m.rt    = RtIdx;
        {m.rw, m.mr, m.mw, m.m2r, m.br} = {RegWrite, MemRead, MemWrite, MemToReg, Branch};
        m.a = RegData1;
        if (!ALUSrc)      m.b = RegData2;
        else if (ZeroExt) m.b = {16'h0000, Imm16};
        else              m.b = {{16{Imm16[15]}}, Imm16};
        m.ctrl = 4'b0010;
        if      (ALUOp == 3'b000) m.ctrl = 4'b0010;
        else if (ALUOp == 3'b001) m.ctrl = 4'b0110;
        else if (ALUOp == 3'b011) m.ctrl = 4'b0000;
        else if (ALUOp == 3'b100) m.ctrl = 4'b0001;
        else if (ALUOp == 3'b101) m.ctrl = 4'b0111;
        else if (ALUOp == 3'b010) begin
            if      (f == 6'h20) m.ctrl = 4'b0010;
            else if (f == 6'h22) m.ctrl = 4'b0110;
            else if (f == 6'h24) m.ctrl = 4'b0000;
            else if (f == 6'h25) m.ctrl = 4'b0001;
            else if (f == 6'h27) m.ctrl = 4'b0011;
            else if (f == 6'h2A) m.ctrl = 4'b0111;
            else if (f == 6'h2B) m.ctrl = 4'b1011;
            else if (f == 6'h08) m.ctrl = 4'b1000;
            else if (f == 6'h00) begin
                m.ctrl = 4'b1010; m.a = RegData2; m.b = {16'h0000, Imm16};
            end else if (f == 6'h02 && RsIdx[0]) begin
                m.ctrl = 4'b1101; m.a = RegData2; m.b = {27'h0, Imm16[10:6]};
            end else m.ill = 1'b1;
        end else if (ALUOp == 3'b110) begin
            if      (f == 6'h02) m.ctrl = 4'b1001;
            else if (f == 6'h21) begin m.ctrl = 4'b1100; m.b = 32'd1; end
            else if (f == 6'h20) begin m.ctrl = 4'b1100; m.b = 32'd0; end
            else m.ill = 1'b1;
        end else m.ill = 1'b1;
        return m;
    endfunction

    task automatic set_instr(input logic [2:0] op, input logic src, input logic zx,
                             input logic [15:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [5:0] ctl);
        InValid = 1'b1; ALUOp = op; ALUSrc = src; ZeroExt = zx; Imm16 = imm;
        RsIdx = rs; RtIdx = rt; RdIdx = rd; RegData1 = d1; RegData2 = d2;
        {RegWrite, MemRead, MemWrite, MemToReg, Branch, RegDst} = ctl;
    endtask

    // Push the prediction for the current inputs, then advance past the edge
    task automatic cycle();
        sb.push_back(model());
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        set_instr(3'b010, 1'b0, 1'b0, 16'h2020, 5'd1, 5'd2, 5'd3, 32'hAAAA5555, 32'h1234, 6'b100001);
        for (int unsigned i = 0; i < 2; i++) begin
            if (i == 1) begin Stall = 1'b1; Flush = 1'b1; end
            cycle();
            e = sb.pop_front(); last = e; total++;
            if (w_got !== e) begin bad++; $display("FAIL reset[%0d] got=%h exp=%h", i, w_got, e); end
        end
        total++;
        if ({ALUControl, A, B, OutValid, RegWriteQ, IllegalOp} !== {4'b0010, 64'h0, 3'b000}) begin
            bad++; $display("FAIL reset_vals got=%h/%h/%h exp=2/0/0", ALUControl, A, B);
        end
        Rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_rtype_add();
        for (int unsigned i = 0; i < 4; i++) begin
            set_instr(3'b010, 1'b0, 1'b0, 16'h0020, 5'(i + 1), 5'(i + 9), 5'(i + 17),
                      $urandom, $urandom, 6'b100001);
            cycle();
            e = sb.pop_front(); last = e; total++;
            if (w_got !== e) begin bad++; $display("FAIL add[%0d] got=%h exp=%h", i, w_got, e); end
        end
        total++;
        if (ALUControl !== 4'b0010 || DestIdx !== 5'd20 || OutValid !== 1'b1) begin
            bad++; $display("FAIL add_ctrl got=%b/%0d exp=0010/20", ALUControl, DestIdx);
        end
    endtask

    task automatic test_sll();
        set_instr(3'b010, 1'b0, 1'b0, 16'h0140, 5'd2, 5'd3, 5'd4, 32'hDEADBEEF, 32'h3, 6'b100001);
        cycle();
        e = sb.pop_front(); last = e; total++;
        if (w_got !== e) begin bad++; $display("FAIL sll got=%h exp=%h", w_got, e); end
        total++;
        if ({ALUControl, A, B} !== {4'b1010, 32'h3, 32'h140}) begin
            bad++; $display("FAIL sll_ops got=%b %h %h exp=1010 3 140", ALUControl, A, B);
        end
    endtask

    task automatic test_rotr();
        set_instr(3'b010, 1'b0, 1'b0, 16'h0102, 5'd1, 5'd5, 5'd6, 32'h0BADF00D, 32'h12345678, 6'b100001);
        cycle();
        e = sb.pop_front(); last = e; total++;
        if ({ALUControl, A, B, IllegalOp} !== {4'b1101, 32'h12345678, 32'd4, 1'b0}) begin
            bad++; $display("FAIL rotr got=%b %h %h exp=1101 12345678 4", ALUControl, A, B);
        end
        RsIdx = 5'd0;
        cycle();
        e = sb.pop_front(); last = e; total++;
        if ({ALUControl, IllegalOp, A, B} !== {4'b0010, 1'b1, 32'h0BADF00D, 32'h12345678}) begin
            bad++; $display("FAIL rotr_rs0 got=%b ill=%b exp=0010 ill=1", ALUControl, IllegalOp);
        end
    endtask

    task automatic test_imm_ext();
        set_instr(3'b000, 1'b1, 1'b0, 16'hFFFC, 5'd7, 5'd8, 5'd9, 32'h100, 32'h55, 6'b100000);
        cycle();
        e = sb.pop_front(); last = e; total++;
        if (B !== 32'hFFFFFFFC || ALUControl !== 4'b0010) begin
            bad++; $display("FAIL sext got=%h exp=FFFFFFFC", B);
        end
        ALUOp = 3'b100; ZeroExt = 1'b1;
        cycle();
        e = sb.pop_front(); last = e; total++;
        if (B !== 32'h0000FFFC || ALUControl !== 4'b0001) begin
            bad++; $display("FAIL zext got=%h/%b exp=0000FFFC/0001", B, ALUControl);
        end
        for (int unsigned k = 0; k < 3; k++) begin
            ALUOp = (k == 0) ? 3'b001 : (k == 1) ? 3'b011 : 3'b101;
            ZeroExt = k[0]; Imm16 = 16'h8001 + 16'(k);
            cycle();
            e = sb.pop_front(); last = e; total++;
            if (w_got !== e) begin bad++; $display("FAIL imm_op[%0d] got=%h exp=%h", k, w_got, e); end
        end
    endtask

    task automatic test_stall_flush();
        set_instr(3'b010, 1'b0, 1'b0, 16'h0020, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 6'b100001);
        cycle();
        e = sb.pop_front(); last = e;
        Stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            set_instr(3'b010, 1'b0, 1'b0, 16'h0022, 5'(10 + i), 5'd11, 5'd12, $urandom, $urandom, 6'b011010);
            cycle();
            e = sb.pop_front(); last = e; total++;
            if (w_got !== e || ALUControl !== 4'b0010 || A !== 32'h11) begin
                bad++; $display("FAIL stall[%0d] got=%h exp=%h", i, w_got, e);
            end
        end
        Flush = 1'b1;
        cycle();
        e = sb.pop_front(); last = e; total++;
        if (w_got !== e || OutValid !== 1'b0 || RegWriteQ !== 1'b0) begin
            bad++; $display("FAIL flush_in_stall got=%h exp=%h", w_got, e);
        end
        Flush = 1'b0; Stall = 1'b0;
        cycle();
        e = sb.pop_front(); last = e; total++;
        if (w_got !== e || ALUControl !== 4'b0110) begin
            bad++; $display("FAIL after_flush got=%h exp=%h", w_got, e);
        end
        Stall = 1'b1; Rst = 1'b1;
        cycle();
        e = sb.pop_front(); last = e; total++;
        if (w_got !== e) begin bad++; $display("FAIL rst_in_stall got=%h exp=%h", w_got, e); end
        Stall = 1'b0; Rst = 1'b0;
    endtask

    task automatic test_special2();
        logic [5:0] fn [4] = '{6'h21, 6'h20, 6'h02, 6'h05};
        logic [31:0] bexp [4] = '{32'd1, 32'd0, 32'hCAFE0001, 32'h0000_FF00};
        logic [3:0] cexp [4] = '{4'b1100, 4'b1100, 4'b1001, 4'b0010};
        for (int unsigned i = 0; i < 4; i++) begin
            set_instr(3'b110, i[1] & i[0], 1'b1, 16'hFF00 | 16'(fn[i]), 5'd1, 5'd2, 5'd3,
                      32'h77, 32'hCAFE0001, 6'b100001);
            if (i == 3) Imm16 = 16'hFF00;
            cycle();
            e = sb.pop_front(); last = e; total++;
            if (w_got !== e || ALUControl !== cexp[i] || B !== bexp[i] || IllegalOp !== (i == 3)) begin
                bad++; $display("FAIL spec2[%0d] got=%b %h exp=%b %h", i, ALUControl, B, cexp[i], bexp[i]);
            end
        end
    endtask

    task automatic test_illegal_invalid();
        set_instr(3'b111, 1'b0, 1'b0, 16'h0020, 5'd4, 5'd5, 5'd6, 32'h9, 32'hA, 6'b100001);
        cycle();
        e = sb.pop_front(); last = e; total++;
        if (w_got !== e || IllegalOp !== 1'b1 || ALUControl !== 4'b0010) begin
            bad++; $display("FAIL op111 got=%h exp=%h", w_got, e);
        end
        ALUOp = 3'b010; Imm16 = 16'h003F;
        cycle();
        e = sb.pop_front(); last = e; total++;
        if (w_got !== e || IllegalOp !== 1'b1) begin bad++; $display("FAIL bad_funct got=%h exp=%h", w_got, e); end
        InValid = 1'b0;
        cycle();
        e = sb.pop_front(); last = e; total++;
        if (w_got !== e || OutValid !== 1'b0 || IllegalOp !== 1'b0) begin
            bad++; $display("FAIL invalid got=%h exp=%h", w_got, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] rf [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h08, 6'h02, 6'h11};
        for (int unsigned i = 0; i < 60; i++) begin
            set_instr(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 16'($urandom),
                      5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, 6'($urandom));
            if ($urandom_range(0, 1) == 1) Imm16[5:0] = rf[$urandom_range(0, 10)];
            InValid = ($urandom_range(0, 7) != 0);
            Stall   = ($urandom_range(0, 5) == 0);
            Flush   = ($urandom_range(0, 9) == 0);
            cycle();
            e = sb.pop_front(); last = e; total++;
            if (w_got !== e) begin bad++; $display("FAIL b2b[%0d] got=%h exp=%h", i, w_got, e); end
        end
        Stall = 1'b0; Flush = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        set_instr(3'b000, 1'b0, 1'b0, 16'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 6'b0);
        last = bubble();
        @(posedge Clk);
        #1;
        test_reset();
        test_rtype_add();
        test_sll();
        test_rotr();
        test_imm_ext();
        test_stall_flush();
        test_special2();
        test_illegal_invalid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_alu_stage.md
Name: id_ex_alu_stage

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit execute ALU.
- Registers decode-stage operands and control, and decodes ALUOp/funct into the ALU's 4-bit ALUControl code.
- Forms the ALU B operand: register, sign/zero-extended immediate, shamt carrier, or CLO/CLZ select bit.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- NOP_CTRL, 4'b0010, ALUControl value driven in a bubble or after reset (ADD).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Stall  in  1  hold all output registers.
- Flush  in  1  load a bubble on the next edge.
- InValid  in  1  decode stage holds a real instruction.
- ALUOp  in  3  class from the main controller: 000 ADD, 001 SUB, 010 R-type, 011 ANDI, 100 ORI, 101 SLTI, 110 SPECIAL2.
- ALUSrc  in  1  1 selects the immediate for B.
- ZeroExt  in  1  1 zero-extends Imm16, 0 sign-extends it.
- Imm16  in  16  instr[15:0]; funct = Imm16[5:0], shamt = Imm16[10:6].
- RsIdx, RtIdx, RdIdx  in  5 each  register indices.
- RegData1, RegData2  in  32 each  register file read data.
- RegWrite, MemRead, MemWrite, MemToReg, Branch, RegDst  in  1 each  control signals passed through.
- OutValid  out  1  registered valid.
- ALUControl  out  4  ALU operation code.
- A, B  out  32 each  ALU operands.
- StoreData  out  32  registered RegData2, for stores.
- DestIdx  out  5  RdIdx if RegDst=1, else RtIdx.
- RsIdxQ, RtIdxQ  out  5 each  registered indices, for forwarding.
- RegWriteQ, MemReadQ, MemWriteQ, MemToRegQ, BranchQ  out  1 each  registered control.
- IllegalOp  out  1  registered; decode fell to the default entry.

Behaviour:
- Reset (Rst=1 at edge):
  - ALUControl=NOP_CTRL.
  - All data, index and control outputs = 0, including OutValid, IllegalOp and every *Q output.
  - Rst overrides Flush and Stall.
- Update priority at each edge: Rst > Flush > Stall > load.
- Flush: loads a bubble, identical to the reset values. Flush overrides Stall.
- Stall (without Flush): every output holds its value.
- Load: all outputs take the decoded values from the inputs. Latency is exactly 1 cycle.
- InValid=0 on a load: loads a bubble; IllegalOp=0.
- ALUControl decode, by ALUOp:
  - 000 → 0010. 001 → 0110. 011 → 0000. 100 → 0001. 101 → 0111.
  - 010, by funct: 100000→0010; 100010→0110; 100100→0000; 100101→0001; 100111→0011; 101010→0111; 101011→1011 (SGT); 000000→1010 (SLL); 001000→1000 (JR).
  - 010, funct 000010: → 1101 (ROTR) only when RsIdx[0]=1; otherwise it is illegal.
  - 110, by funct: 000010→1001 (MUL); 100001→1100 (CLO); 100000→1100 (CLZ).
  - 111, or any unlisted funct → 0010, with IllegalOp=1.
- Operand A: always RegData1, except A=RegData2 for SLL and ROTR (value to shift).
- Operand B:
  - SLL → {16'b0, Imm16}, so the shamt appears at B[10:6].
  - ROTR → {27'b0, Imm16[10:6]}.
  - CLO → 32'd1. CLZ → 32'd0.
  - Otherwise ALUSrc=1 → extended Imm16 (ZeroExt selects zero- or sign-extension).
  - Otherwise → RegData2.
- Bubble encoding: all write/memory/branch controls = 0. A bubble therefore has no architectural effect even though the ALU computes 0+0.
- Inputs may change arbitrarily while Stall=1. Outputs must not glitch across the edge.
- Reset or Flush asserted mid-stall discards the held instruction.

Test Plan:
- Rst=1 for 2 cycles → ALUControl=0010, A=B=0, OutValid=0, RegWriteQ=0. Then Rst=0 with a stream of R-type add → ALUControl=0010 one cycle later.
- ALUOp=010, Imm16=0x0140 (SLL, shamt 5), RegData2=0x00000003 → A=0x00000003, B=0x00000140, ALUControl=1010.
- ALUOp=010, funct 000010, RsIdx=1, Imm16 shamt=4, RegData2=0x12345678 → ALUControl=1101, A=0x12345678, B=4. The same input with RsIdx=0 → ALUControl=0010, IllegalOp=1.
- ALUOp=000, ALUSrc=1, ZeroExt=0, Imm16=0xFFFC → B=0xFFFFFFFC. Then ALUOp=100, ZeroExt=1, same Imm16 → B=0x0000FFFC, ALUControl=0001.
- Load add, then Stall=1 for 3 cycles while the inputs change to sub → outputs hold add. Assert Flush with Stall still high → next edge gives a bubble (OutValid=0, ALUControl=0010, controls 0).
- ALUOp=110, funct 100001 (CLO) → ALUControl=1100, B=1. funct 100000 (CLZ) → B=0. funct 000010 (MUL) → ALUControl=1001, B=RegData2.
